cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single 40-bit common data bus (CDB) among the result producers: adder, multiplier and load unit.
- Each producer presents a {tag[7:0], data[31:0]} result through a valid/ready handshake.
- The block buffers one result per producer and grants the bus round-robin, one result per cycle.
- It drives a registered broadcast that the reservation stations snoop for tag matches. Tag 8'h00 on the bus means "no result".

Parameters:
- NUM_REQ, 3, number of producers; index 0=adder, 1=multiplier, 2=load.
- TAG_W, 8, tag field width.
- DATA_W, 32, data field width.

Ports:
- clk  input  1  clock; all state changes on posedge clk.
- rst_n  input  1  reset, asynchronous and active-low.
- req_valid  input  NUM_REQ  per-producer result valid.
- req_bus  input  NUM_REQ*(TAG_W+DATA_W)  packed results; slice i = bits [(i+1)*40-1 : i*40], {tag, data}.
- req_ready  output  NUM_REQ  per-producer ready; combinational.
- cdb_valid  output  1  broadcast valid; registered.
- cdb_bus  output  TAG_W+DATA_W  broadcast {tag, data}; registered.
- cdb_src  output  clog2(NUM_REQ)  index of the producer that owns the current broadcast.
- tag0_err  output  1  one-cycle pulse: a valid request carried tag 0 and was dropped.
- busy  output  1  at least one holding buffer is occupied; combinational.

Behaviour:
- Reset (rst_n=0, asynchronous): all holding buffers empty; cdb_valid=0; cdb_bus=0; cdb_src=0; tag0_err=0; round-robin pointer rr=0.
- Reset asserted mid-operation discards all buffered results. No grant is issued in the first cycle after release.
- Holding buffer: each producer i has one entry, hold_v[i] plus a 40-bit payload.
- req_ready[i] = ~hold_v[i] | grant[i]. This allows one accepted result per cycle per producer in steady state.
- Accept: when req_valid[i] & req_ready[i], the payload is written to hold[i] at posedge.
  - Tag 0: if the payload tag is 0, the write is suppressed, the request is still consumed, and tag0_err=1 in the next cycle.
  - Multiple tag-0 drops in one cycle produce a single pulse.
- Grant: combinational.
  - Candidates are the producers with hold_v set.
  - The winner is the first candidate at or after rr, searching upward with wrap-around modulo NUM_REQ.
  - At most one grant per cycle.
- Grant update at posedge:
  - cdb_bus <= hold[g]; cdb_valid <= 1; cdb_src <= g.
  - hold_v[g] is cleared, unless refilled in the same cycle; refill takes precedence.
  - rr <= (g+1) mod NUM_REQ.
- No candidate at posedge: cdb_valid <= 0; cdb_bus <= 40'h0 so the tag is 0; cdb_src holds; rr holds.
- Latency: result accepted in cycle N appears on the CDB at the earliest after the posedge ending cycle N+1, i.e. one buffer cycle plus one output register.
- A freshly written entry is not a candidate in its write cycle.
- Fairness: a buffered result waits at most NUM_REQ-1 grants. No producer starves.
- Simultaneous events:
  - Several producers become valid together: they are granted in rr order on consecutive cycles.
  - A producer granted and re-accepting in the same cycle keeps hold_v=1.
- CDB is single-cycle: each broadcast is valid for exactly one cycle. Consumers have no backpressure.
- Data is never modified; the bus carries exactly {tag, data} as accepted.
- busy = |hold_v. It is independent of cdb_valid.

Test Plan:
- Reset: hold rst_n=0 with req_valid=3'b111 -> req_ready=3'b111 after release, cdb_valid=0, cdb_bus=0.
- Reset mid-stream: assert rst_n=0 while hold_v is nonzero -> immediate clear, cdb_valid=0, no grant in the cycle after release.
- Single producer: multiplier presents {8'h30, 32'd42} for one cycle -> two cycles later cdb_bus=40'h30_0000002A, cdb_valid=1, cdb_src=1; next cycle cdb_valid=0, tag 0.
- Contention: all three valid in one cycle, tags A0/M0/LD0, rr=0 -> CDB shows 8'h20, 8'h30, 8'h40 on three consecutive cycles; rr ends at 0.
- Fairness and back-to-back:
  - Adder streams a new result every cycle while the load unit posts {8'h41, 32'h5}.
  - Load is broadcast within 2 grants.
  - Adder sees req_ready stay high whenever it is granted.
- Tag-0 drop: adder presents {8'h00, 32'hDEAD} -> req_ready=1, no broadcast, tag0_err pulses for exactly one cycle, busy stays 0.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signals of the common data bus arbiter.
// The arbiter takes the slave modport; producers and snoopers take the master.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 8,
    parameter int DATA_W  = 32
);
    localparam int W     = TAG_W + DATA_W;
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*W-1:0] req_bus;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 cdb_valid;
    logic [W-1:0]         cdb_bus;
    logic [SRC_W-1:0]     cdb_src;
    logic                 tag0_err;
    logic                 busy;

    modport master (
        output req_valid, req_bus,
        input  req_ready, cdb_valid, cdb_bus, cdb_src, tag0_err, busy
    );

    modport slave (
        input  req_valid, req_bus,
        output req_ready, cdb_valid, cdb_bus, cdb_src, tag0_err, busy
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered {tag, data} broadcast bus among
// the result producers, with one holding buffer per producer.
module cdb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 8,
    parameter int DATA_W  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    cdb_arbiter_if.slave  cdb
);
    localparam int W     = TAG_W + DATA_W;
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] r_hold_v;
    logic [W-1:0]       r_hold [NUM_REQ];
    logic [SRC_W-1:0]   r_rr;
    logic               r_cdb_valid;
    logic [W-1:0]       r_cdb_bus;
    logic [SRC_W-1:0]   r_cdb_src;
    logic               r_tag0_err;

    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_ready;
    logic [NUM_REQ-1:0] w_drop;
    logic [NUM_REQ-1:0] w_write;
    logic [SRC_W-1:0]   w_gidx;
    logic [SRC_W-1:0]   w_idx;
    logic               w_gvalid;

    // Round-robin winner: first occupied buffer at or after r_rr, wrapping.
    always_comb begin
        w_gvalid = 1'b0;
        w_gidx   = {SRC_W{1'b0}};
        w_idx    = {SRC_W{1'b0}};
        w_grant  = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = SRC_W'((int'(r_rr) + k) % NUM_REQ);
            if (!w_gvalid && r_hold_v[w_idx]) begin
                w_gvalid = 1'b1;
                w_gidx   = w_idx;
            end else begin
                w_gvalid = w_gvalid;
            end
        end
        if (w_gvalid) begin
            w_grant[w_gidx] = 1'b1;
        end else begin
            w_grant = {NUM_REQ{1'b0}};
        end
    end

    // Accept classification; a tag-0 result is consumed but never buffered.
    always_comb begin
        w_ready = ~r_hold_v | w_grant;
        w_drop  = {NUM_REQ{1'b0}};
        w_write = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cdb.req_bus[i*W+DATA_W +: TAG_W] == {TAG_W{1'b0}}) begin
                w_drop[i]  = cdb.req_valid[i] & w_ready[i];
                w_write[i] = 1'b0;
            end else begin
                w_drop[i]  = 1'b0;
                w_write[i] = cdb.req_valid[i] & w_ready[i];
            end
        end
    end

    // Holding buffers: a refill wins over the clear caused by a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_v <= {NUM_REQ{1'b0}};
            for (int i = 0; i < NUM_REQ; i++) begin
                r_hold[i] <= {W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_write[i]) begin
                    r_hold_v[i] <= 1'b1;
                    r_hold[i]   <= cdb.req_bus[i*W +: W];
                end else if (w_grant[i]) begin
                    r_hold_v[i] <= 1'b0;
                end else begin
                    r_hold_v[i] <= r_hold_v[i];
                end
            end
        end
    end

    // Broadcast register, round-robin pointer and tag-0 error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cdb_valid <= 1'b0;
            r_cdb_bus   <= {W{1'b0}};
            r_cdb_src   <= {SRC_W{1'b0}};
            r_rr        <= {SRC_W{1'b0}};
            r_tag0_err  <= 1'b0;
        end else begin
            r_tag0_err <= |w_drop;
            if (w_gvalid) begin
                r_cdb_valid <= 1'b1;
                r_cdb_bus   <= r_hold[w_gidx];
                r_cdb_src   <= w_gidx;
                if (w_gidx == SRC_W'(NUM_REQ - 1)) begin
                    r_rr <= {SRC_W{1'b0}};
                end else begin
                    r_rr <= w_gidx + SRC_W'(1);
                end
            end else begin
                r_cdb_valid <= 1'b0;
                r_cdb_bus   <= {W{1'b0}};
            end
        end
    end

    assign cdb.req_ready = w_ready;
    assign cdb.busy      = |r_hold_v;
    assign cdb.cdb_valid = r_cdb_valid;
    assign cdb.cdb_bus   = r_cdb_bus;
    assign cdb.cdb_src   = r_cdb_src;
    assign cdb.tag0_err  = r_tag0_err;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic
// compared against a cycle-level model of the arbitration rules.
module tb_cdb_arbiter;
    localparam int N = 3;
    localparam int W = 40;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    cdb_arbiter_if #(.NUM_REQ(N), .TAG_W(8), .DATA_W(32)) bus_if ();

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(8), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cdb   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: one slot per producer, pointer, expected registered outputs.
    logic         m_v [N];
    logic [W-1:0] m_d [N];
    int           m_rr;
    logic         e_valid;
    logic [W-1:0] e_bus;
    int           e_src;
    logic         e_tag0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = '0;
        end
        m_rr = 0; e_valid = 1'b0; e_bus = '0; e_src = 0; e_tag0 = 1'b0;
    endtask

    function automatic int model_winner();
        int g;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && m_v[(m_rr + k) % N]) g = (m_rr + k) % N;
        return g;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        g = model_winner();
        for (int i = 0; i < N; i++) r[i] = !m_v[i] || (g == i);
        return r;
    endfunction

    function automatic logic model_busy();
        logic b;
        b = 1'b0;
        for (int i = 0; i < N; i++) b = b | m_v[i];
        return b;
    endfunction

    // Advance one clock from a negedge to the next, updating the model.
    task automatic step();
        int g;
        logic [N-1:0] rdy;
        logic drop;
        logic [W-1:0] p;
        g = model_winner();
        rdy = model_ready();
        @(posedge clk);
        drop = 1'b0;
        if (g >= 0) begin
            e_valid = 1'b1; e_bus = m_d[g]; e_src = g;
            m_rr = (g + 1) % N; m_v[g] = 1'b0;
        end else begin
            e_valid = 1'b0; e_bus = '0;
        end
        for (int i = 0; i < N; i++) begin
            p = bus_if.req_bus[i*W +: W];
            if (bus_if.req_valid[i] && rdy[i]) begin
                if (p[39:32] == 8'h00) drop = 1'b1;
                else begin m_v[i] = 1'b1; m_d[i] = p; end
            end
        end
        e_tag0 = drop;
        @(negedge clk);
    endtask

    function automatic logic [7:0] rnd_tag();
        logic [7:0] t;
        t = 8'($urandom_range(1, 255));
        return t;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.req_valid = 3'b111;
        bus_if.req_bus = {8'h12, 32'h1, 8'h11, 32'h2, 8'h10, 32'h3};
        repeat (2) @(negedge clk);
        model_reset();
        checks++; if (bus_if.cdb_valid !== 1'b0 || bus_if.cdb_bus !== 40'h0) begin
            errors++; $display("FAIL reset_out: got valid=%b bus=%h want 0/0", bus_if.cdb_valid, bus_if.cdb_bus); end
        checks++; if (bus_if.busy !== 1'b0 || bus_if.tag0_err !== 1'b0 || bus_if.cdb_src !== 2'd0) begin
            errors++; $display("FAIL reset_state: got busy=%b tag0=%b src=%0d want 0", bus_if.busy, bus_if.tag0_err, bus_if.cdb_src); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus_if.req_ready !== 3'b111) begin
            errors++; $display("FAIL reset_ready: got %b want 111", bus_if.req_ready); end
        step();
        bus_if.req_valid = 3'b000;
        checks++; if (bus_if.cdb_valid !== 1'b0 || bus_if.busy !== 1'b1) begin
            errors++; $display("FAIL reset_first_cycle: got valid=%b busy=%b want 0/1", bus_if.cdb_valid, bus_if.busy); end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (bus_if.cdb_valid !== e_valid || bus_if.cdb_bus !== e_bus) begin
                errors++; $display("FAIL reset_drain: got %b/%h want %b/%h", bus_if.cdb_valid, bus_if.cdb_bus, e_valid, e_bus); end
        end
    endtask

    task automatic test_contention();
        logic [7:0] tags [3];
        tags[0] = 8'h20; tags[1] = 8'h30; tags[2] = 8'h40;
        bus_if.req_valid = 3'b111;
        bus_if.req_bus = {8'h40, $urandom(), 8'h30, $urandom(), 8'h20, $urandom()};
        step();
        bus_if.req_valid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus_if.cdb_valid !== 1'b1 || bus_if.cdb_bus[39:32] !== tags[k] || bus_if.cdb_src !== 2'(k)) begin
                errors++; $display("FAIL contention_%0d: got v=%b tag=%h src=%0d want 1/%h/%0d", k, bus_if.cdb_valid, bus_if.cdb_bus[39:32], bus_if.cdb_src, tags[k], k); end
            checks++; if (bus_if.cdb_bus !== e_bus) begin
                errors++; $display("FAIL contention_data_%0d: got %h want %h", k, bus_if.cdb_bus, e_bus); end
        end
        step();
        checks++; if (bus_if.cdb_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL contention_idle: got v=%b busy=%b want 0/0", bus_if.cdb_valid, bus_if.busy); end
    endtask

    task automatic test_single();
        bus_if.req_valid = 3'b010;
        bus_if.req_bus = {40'h0, 8'h30, 32'd42, 40'h0};
        #1;
        checks++; if (bus_if.req_ready[1] !== 1'b1) begin
            errors++; $display("FAIL single_ready: got %b want 1", bus_if.req_ready[1]); end
        step();
        bus_if.req_valid = 3'b000;
        checks++; if (bus_if.cdb_valid !== 1'b0) begin
            errors++; $display("FAIL single_latency: got valid=%b want 0", bus_if.cdb_valid); end
        step();
        checks++; if (bus_if.cdb_valid !== 1'b1 || bus_if.cdb_bus !== 40'h30_0000002A || bus_if.cdb_src !== 2'd1) begin
            errors++; $display("FAIL single_bcast: got %b/%h/%0d want 1/300000002a/1", bus_if.cdb_valid, bus_if.cdb_bus, bus_if.cdb_src); end
        step();
        checks++; if (bus_if.cdb_valid !== 1'b0 || bus_if.cdb_bus[39:32] !== 8'h00) begin
            errors++; $display("FAIL single_after: got v=%b tag=%h want 0/00", bus_if.cdb_valid, bus_if.cdb_bus[39:32]); end
    endtask

    task automatic test_mid_reset();
        bus_if.req_valid = 3'b111;
        bus_if.req_bus = {rnd_tag(), $urandom(), rnd_tag(), $urandom(), rnd_tag(), $urandom()};
        step();
        bus_if.req_valid = 3'b000;
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (bus_if.busy !== 1'b0 || bus_if.cdb_valid !== 1'b0 || bus_if.cdb_bus !== 40'h0) begin
            errors++; $display("FAIL midreset_clear: got busy=%b v=%b bus=%h want 0/0/0", bus_if.busy, bus_if.cdb_valid, bus_if.cdb_bus); end
        checks++; if (bus_if.req_ready !== 3'b111) begin
            errors++; $display("FAIL midreset_ready: got %b want 111", bus_if.req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (bus_if.cdb_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_nogrant: got v=%b want 0", bus_if.cdb_valid); end
    endtask

    task automatic test_back_to_back();
        int grants;
        int seen_at;
        grants = 0; seen_at = -1;
        for (int c = 0; c < 10; c++) begin
            bus_if.req_valid = (c == 0) ? 3'b101 : 3'b001;
            bus_if.req_bus = {8'h41, 32'h5, 40'h0, 8'(8'h50 + c), 32'(c)};
            #1;
            checks++; if (bus_if.req_ready !== model_ready() || (model_winner() == 0 && bus_if.req_ready[0] !== 1'b1)) begin
                errors++; $display("FAIL b2b_ready_%0d: got %b want %b", c, bus_if.req_ready, model_ready()); end
            step();
            checks++; if (bus_if.cdb_valid !== e_valid || bus_if.cdb_bus !== e_bus) begin
                errors++; $display("FAIL b2b_bus_%0d: got %b/%h want %b/%h", c, bus_if.cdb_valid, bus_if.cdb_bus, e_valid, e_bus); end
            if (bus_if.cdb_valid === 1'b1) grants++;
            if (bus_if.cdb_valid === 1'b1 && bus_if.cdb_src === 2'd2 && seen_at < 0) begin
                seen_at = grants;
                checks++; if (bus_if.cdb_bus !== 40'h41_00000005) begin
                    errors++; $display("FAIL b2b_load_data: got %h want 4100000005", bus_if.cdb_bus); end
            end
        end
        checks++; if (seen_at < 1 || seen_at > 2) begin
            errors++; $display("FAIL b2b_fair: got load at grant %0d want 1..2", seen_at); end
        bus_if.req_valid = 3'b000;
        repeat (3) step();
    endtask

    task automatic test_tag0();
        bus_if.req_valid = 3'b001;
        bus_if.req_bus = {80'h0, 8'h00, 32'hDEAD};
        #1;
        checks++; if (bus_if.req_ready[0] !== 1'b1) begin
            errors++; $display("FAIL tag0_ready: got %b want 1", bus_if.req_ready[0]); end
        step();
        bus_if.req_valid = 3'b000;
        checks++; if (bus_if.tag0_err !== 1'b1 || bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL tag0_pulse: got err=%b busy=%b want 1/0", bus_if.tag0_err, bus_if.busy); end
        step();
        checks++; if (bus_if.tag0_err !== 1'b0 || bus_if.cdb_valid !== 1'b0) begin
            errors++; $display("FAIL tag0_end: got err=%b v=%b want 0/0", bus_if.tag0_err, bus_if.cdb_valid); end
        bus_if.req_valid = 3'b101;
        bus_if.req_bus = {8'h00, 32'h1, 8'h33, 32'h2, 8'h00, 32'h3};
        step();
        bus_if.req_valid = 3'b000;
        checks++; if (bus_if.tag0_err !== 1'b1) begin
            errors++; $display("FAIL tag0_multi: got %b want 1", bus_if.tag0_err); end
        step();
        checks++; if (bus_if.tag0_err !== 1'b0) begin
            errors++; $display("FAIL tag0_multi_end: got %b want 0", bus_if.tag0_err); end
    endtask

    task automatic test_random();
        logic [7:0] t [N];
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) t[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : rnd_tag();
            bus_if.req_valid = 3'($urandom_range(0, 7));
            bus_if.req_bus = {t[2], $urandom(), t[1], $urandom(), t[0], $urandom()};
            #1;
            checks++; if (bus_if.req_ready !== model_ready() || bus_if.busy !== model_busy()) begin
                errors++; $display("FAIL rand_ready_%0d: got %b/%b want %b/%b", c, bus_if.req_ready, bus_if.busy, model_ready(), model_busy()); end
            step();
            checks++; if (bus_if.cdb_valid !== e_valid || bus_if.cdb_bus !== e_bus
                          || bus_if.cdb_src !== 2'(e_src) || bus_if.tag0_err !== e_tag0) begin
                errors++; $display("FAIL rand_out_%0d: got %b/%h/%0d/%b want %b/%h/%0d/%b", c,
                    bus_if.cdb_valid, bus_if.cdb_bus, bus_if.cdb_src, bus_if.tag0_err, e_valid, e_bus, e_src, e_tag0); end
        end
        bus_if.req_valid = 3'b000;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus_if.req_valid = '0;
        bus_if.req_bus = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_contention();
        test_single();
        test_mid_reset();
        test_back_to_back();
        test_tag0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
